// File: rtl/crc_pkg.sv
// Shared definitions for the CRC core: register map, CTRL bit positions and FSM states.
// Also provides a helper that assembles the CTRL read value.
package crc_pkg;

    localparam logic [31:0] AddrData  = 32'h0000_0000;
    localparam logic [31:0] AddrGpoly = 32'h0000_0004;
    localparam logic [31:0] AddrCtrl  = 32'h0000_0008;

    localparam int unsigned CtrlTcrc = 24;
    localparam int unsigned CtrlWas  = 25;
    localparam int unsigned CtrlOvr  = 26;
    localparam int unsigned CtrlBusy = 27;

    typedef enum logic {
        StIdle,
        StRun
    } crc_state_e;

    function automatic logic [31:0] ctrl_word(input logic tcrc, input logic was,
                                              input logic ovr, input logic busy);
        logic [31:0] w;
        w           = '0;
        w[CtrlTcrc] = tcrc;
        w[CtrlWas]  = was;
        w[CtrlOvr]  = ovr;
        w[CtrlBusy] = busy;
        return w;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational one-byte CRC update, MSB first, in 32-bit or 16-bit mode.
// In 16-bit mode only poly[15:0] is used and the result is masked to 16 bits.
module crc_byte_step (
    input  logic [31:0] crc,
    input  logic [7:0]  data_byte,
    input  logic [31:0] poly,
    input  logic        tcrc,
    output logic [31:0] crc_next
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (tcrc) begin
                fb = c[31] ^ data_byte[i];
                c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
            end else begin
                fb = c[15] ^ data_byte[i];
                c  = {16'h0, c[14:0], 1'b0} ^ (fb ? {16'h0, poly[15:0]} : 32'h0);
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc_core.sv
// Register-mapped CRC engine: DATA/GPOLY/CTRL registers and a byte-serial FSM
// that folds one 32-bit word into the CRC over four cycles.
module crc_core
    import crc_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'hFFFF_FFFF,
    parameter logic [31:0] RESET_POLY = 32'h04C1_1DB7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    input  logic        rw,
    input  logic        sel,
    output logic [31:0] data_rd,
    output logic        busy
);

    crc_state_e  state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [31:0] crc_q;
    logic [31:0] gpoly_q;
    logic        tcrc_q;
    logic        was_q;
    logic        ovr_q;

    logic        rd_en;
    logic        wr_data;
    logic        wr_gpoly;
    logic        wr_ctrl;
    logic        set_ovr;
    logic        clr_ovr;
    logic [31:0] rd_val;
    logic [31:0] crc_step;

    assign busy = (state_q == StRun);

    crc_byte_step u_byte_step (
        .crc       (crc_q),
        .data_byte (word_q[31:24]),
        .poly      (gpoly_q),
        .tcrc      (tcrc_q),
        .crc_next  (crc_step)
    );

    always_comb begin
        rd_en    = sel & ~rw;
        wr_data  = sel & rw & (addr == AddrData);
        wr_gpoly = sel & rw & (addr == AddrGpoly);
        wr_ctrl  = sel & rw & (addr == AddrCtrl);
        set_ovr  = wr_data & busy;
        clr_ovr  = wr_ctrl & data_wr[CtrlOvr];
        rd_val   = 32'h0;
        if (addr == AddrData) begin
            rd_val = crc_q;
        end else if (addr == AddrGpoly) begin
            rd_val = gpoly_q;
        end else if (addr == AddrCtrl) begin
            rd_val = ctrl_word(tcrc_q, was_q, ovr_q, busy);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
            crc_q      <= RESET_SEED;
            gpoly_q    <= RESET_POLY;
            tcrc_q     <= 1'b0;
            was_q      <= 1'b0;
            ovr_q      <= 1'b0;
            data_rd    <= 32'h0;
        end else begin
            if (rd_en) begin
                data_rd <= rd_val;
            end

            // A set wins over a simultaneous write-1-to-clear.
            ovr_q <= set_ovr | (ovr_q & ~clr_ovr);

            if (wr_ctrl) begin
                was_q <= data_wr[CtrlWas];
                if (!busy) begin
                    tcrc_q <= data_wr[CtrlTcrc];
                end
            end

            if (wr_gpoly && !busy) begin
                gpoly_q <= data_wr;
            end

            unique case (state_q)
                StIdle: begin
                    if (wr_data) begin
                        if (was_q) begin
                            crc_q <= tcrc_q ? data_wr : {16'h0, data_wr[15:0]};
                        end else begin
                            word_q     <= data_wr;
                            byte_cnt_q <= 2'd0;
                            state_q    <= StRun;
                        end
                    end
                end
                StRun: begin
                    // word_q shifts left so the byte being folded is always word_q[31:24].
                    crc_q      <= crc_step;
                    word_q     <= {word_q[23:0], 8'h00};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_core.sv
// Self-checking bench for crc_core: bus-level reads scored against a queue of
// expected values computed from a bit-serial reference CRC.
module tb_crc_core;

    localparam logic [31:0] A_DATA  = 32'h0;
    localparam logic [31:0] A_GPOLY = 32'h4;
    localparam logic [31:0] A_CTRL  = 32'h8;
    localparam logic [31:0] B_TCRC  = 32'h0100_0000;
    localparam logic [31:0] B_WAS   = 32'h0200_0000;
    localparam logic [31:0] B_OVR   = 32'h0400_0000;
    localparam logic [31:0] P32     = 32'h04C1_1DB7;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rw;
    logic        sel;
    logic [31:0] data_rd;
    logic        busy;

    int total;
    int bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp_crc;
    int          nbusy;

    crc_core dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_wr (data_wr),
        .rw      (rw),
        .sel     (sel),
        .data_rd (data_rd),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bit-serial reference, consumes the top nbits of word MSB first.
    function automatic logic [31:0] crc_ref(input logic [31:0] seed, input logic [31:0] word,
                                            input int nbits, input logic [31:0] poly,
                                            input logic tcrc);
        logic [31:0] c;
        logic        fb;
        c = seed;
        for (int i = 0; i < nbits; i++) begin
            if (tcrc) begin
                fb = c[31] ^ word[31-i];
                c  = (c << 1) ^ (fb ? poly : 32'h0);
            end else begin
                fb = c[15] ^ word[31-i];
                c  = ((c << 1) ^ (fb ? (poly & 32'hFFFF) : 32'h0)) & 32'hFFFF;
            end
        end
        return c;
    endfunction

    // Bus tasks are entered on a falling edge and return on the next one.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel     = 1'b1;
        rw      = 1'b1;
        addr    = a;
        data_wr = d;
        @(negedge clk);
        sel = 1'b0;
        rw  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        sel  = 1'b1;
        rw   = 1'b0;
        addr = a;
        @(negedge clk);
        sel = 1'b0;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, data_rd, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, data_rd, e);
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        sel     = 1'b0;
        rw      = 1'b0;
        addr    = 32'h0;
        data_wr = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_rd", data_rd, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Reset values
        bus_read("reset_data", A_DATA, 32'hFFFF_FFFF);
        bus_read("reset_gpoly", A_GPOLY, P32);
        bus_read("reset_ctrl", A_CTRL, 32'h0);
        check_eq("reset_busy", {31'h0, busy}, 32'h0);

        // 32-bit word
        bus_write(A_CTRL, B_TCRC | B_WAS);
        bus_write(A_DATA, 32'h0);
        check_eq("seed_nobusy", {31'h0, busy}, 32'h0);
        bus_write(A_CTRL, B_TCRC);
        bus_write(A_DATA, 32'h0000_0001);
        wait_idle(nbusy);
        check_eq("crc32_busy_cycles", nbusy, 4);
        bus_read("crc32_data", A_DATA, 32'h04C1_1DB7);

        // Working register visible mid-word; GPOLY and TCRC writes ignored while busy
        bus_write(A_CTRL, B_TCRC | B_WAS);
        bus_write(A_DATA, 32'h0);
        bus_write(A_CTRL, B_TCRC);
        bus_write(A_DATA, 32'h0100_0000);
        @(negedge clk);
        bus_read("busy_working", A_DATA, crc_ref(32'h0, 32'h0100_0000, 8, P32, 1'b1));
        bus_write(A_GPOLY, 32'h0000_AAAA);
        bus_write(A_CTRL, 32'h0);
        wait_idle(nbusy);
        bus_read("busy_gpoly_kept", A_GPOLY, P32);
        bus_read("busy_tcrc_kept", A_CTRL, B_TCRC);
        bus_read("busy_final", A_DATA, crc_ref(32'h0, 32'h0100_0000, 32, P32, 1'b1));

        // 16-bit mode
        bus_write(A_CTRL, B_WAS);
        bus_write(A_GPOLY, 32'h0000_1021);
        bus_write(A_DATA, 32'h0);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DATA, 32'h0000_0001);
        wait_idle(nbusy);
        check_eq("crc16_busy_cycles", nbusy, 4);
        bus_read("crc16_data", A_DATA, 32'h0000_1021);
        bus_write(A_CTRL, B_WAS);
        bus_write(A_DATA, 32'hABCD_1234);
        bus_read("crc16_seed_mask", A_DATA, 32'h0000_1234);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DATA, 32'hCAFE_F00D);
        wait_idle(nbusy);
        exp_crc = crc_ref(32'h0000_1234, 32'hCAFE_F00D, 32, 32'h0000_1021, 1'b0);
        bus_read("crc16_word", A_DATA, exp_crc);

        // Overrun: back-to-back DATA writes
        bus_write(A_DATA, 32'h1111_1111);
        bus_write(A_DATA, 32'hDEAD_BEEF);
        wait_idle(nbusy);
        exp_crc = crc_ref(exp_crc, 32'h1111_1111, 32, 32'h0000_1021, 1'b0);
        bus_read("ovr_data", A_DATA, exp_crc);
        bus_read("ovr_set", A_CTRL, B_OVR);
        bus_write(A_CTRL, B_OVR);
        bus_read("ovr_clear", A_CTRL, 32'h0);

        // Unmapped address
        bus_write(32'h0000_000C, 32'h1234_5678);
        bus_read("unmap_rd", 32'h0000_000C, 32'h0);
        bus_read("unmap_data", A_DATA, exp_crc);
        bus_read("unmap_gpoly", A_GPOLY, 32'h0000_1021);
        bus_read("unmap_ctrl", A_CTRL, 32'h0);

        // Reset two cycles into a word
        bus_write(A_DATA, 32'h5555_AAAA);
        @(negedge clk);
        check_eq("midrst_running", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", {31'h0, busy}, 32'h0);
        check_eq("midrst_rd", data_rd, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read("midrst_data", A_DATA, 32'hFFFF_FFFF);
        bus_read("midrst_gpoly", A_GPOLY, P32);
        bus_read("midrst_ctrl", A_CTRL, 32'h0);
        bus_write(A_CTRL, B_TCRC);
        bus_write(A_DATA, 32'h1234_5678);
        wait_idle(nbusy);
        check_eq("post_rst_cycles", nbusy, 4);
        bus_read("post_rst_crc", A_DATA, crc_ref(32'hFFFF_FFFF, 32'h1234_5678, 32, P32, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
